mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
// Round-robin arbiter and sequencer that shares one Multiplier (N-bit fixed-point,
// enable/reset/finish handshake) between NUM_REQ datapath requesters (e.g. fc_layer
// instances). It owns the multiplier control pins, one product at a time, and returns
// a done pulse plus result to the granted requester. Sits between the layer controllers
// and the single Multiplier instance.
// PARAMETERS
// NUM_REQ  4   number of requesters (2..16)
// N        16  operand/result width; matches Multiplier N
// TIMEOUT  64  max WAIT cycles for mul_finish before forced completion (>=2)
// PORTS
// clk          in   1          clock, rising edge
// reset        in   1          synchronous, active-high
// req          in   NUM_REQ    per-requester request; held high until own done
// op_a         in   NUM_REQ*N  operand M per requester, slice i = [i*N +: N]
// op_b         in   NUM_REQ*N  operand R per requester, slice i = [i*N +: N]
// gnt          out  NUM_REQ    one-hot grant, high START..DONE inclusive
// done         out  NUM_REQ    one-hot 1-cycle pulse, result valid this cycle
// result       out  N          product of granted transaction, held until next DONE
// busy         out  1          high in any state except IDLE
// timeout_err  out  1          sticky; set on forced completion, cleared only by reset
// mul_m        out  N          to Multiplier.M
// mul_r        out  N          to Multiplier.R
// mul_enable   out  1          to Multiplier.enable
// mul_reset    out  1          to Multiplier.reset
// mul_result   in   N          from Multiplier.fixedMulResult
// mul_finish   in   1          from Multiplier.finish
// BEHAVIOUR
// - Reset: state=IDLE, ptr=0, gnt=0, done=0, result=0, busy=0, timeout_err=0,
//   mul_m=0, mul_r=0, mul_enable=0, mul_reset=0, wait counter=0. Reset wins over all.
// - All outputs registered. FSM: IDLE -> START -> WAIT -> DONE -> IDLE.
// - IDLE: if req!=0, winner = first set bit scanning ptr, ptr+1, ... mod NUM_REQ;
//   latch idx, mul_m=op_a[idx], mul_r=op_b[idx]; gnt[idx]=1; go START. Else stay.
// - START (1 cycle): mul_enable=1, mul_reset=1; counter=0; go WAIT.
// - WAIT: mul_enable=1, mul_reset=0; counter++. mul_finish=1 -> result=mul_result,
//   go DONE. Else counter==TIMEOUT-1 -> result=0, timeout_err=1, go DONE.
//   mul_finish on the timeout cycle: finish wins, no error.
// - DONE (1 cycle): done[idx]=1, gnt[idx]=1, mul_enable=0; ptr=(idx+1) mod NUM_REQ;
//   next IDLE, gnt=0.
// - Operands latched once in IDLE; op_a/op_b changes after grant ignored.
// - req drop after grant: transaction still completes, done still pulsed.
// - Requester must drop req in the cycle after its done, else new request
//   (arbitrated fairly, lowest priority after ptr advance).
// - mul_finish outside WAIT ignored.
// - Latency: req seen in IDLE cycle c -> gnt at c+1 (START), mul_enable/mul_reset
//   high c+1, finish in WAIT cycle f -> done at f+1. Min req-to-done = 4 cycles.
// - Back-to-back: IDLE always 1 cycle between transactions (no DONE->START bypass).
// TESTING (stub Multiplier: product = (M*R)>>8, finish L cycles after reset drops)
// 1 req[1]=1, op_a[1]=0x0100, op_b[1]=0x0200, L=5 -> gnt=0010 next cycle,
//   done[1] 1 cycle after finish, result=0x0200, timeout_err=0.
// 2 req=1111 from reset, L=3 -> done order 0,1,2,3; exactly one IDLE cycle between.
// 3 req[0] re-asserted after every done, req[2] held -> grants alternate 0,2,0,2.
// 4 stub never finishes -> done at WAIT cycle TIMEOUT, result=0, timeout_err=1 stays
//   high across later good transactions until reset.
// 5 reset during WAIT -> next cycle all outputs at reset values; req[3] then wins
//   with ptr=0 behaviour.
// 6 req[2] dropped and op_a[2] changed mid-WAIT -> done[2] pulses, result from the
//   latched operands.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
// Round-robin arbiter and sequencer that lets NUM_REQ datapath requesters share
// a single fixed-point Multiplier. One product is computed at a time: the winner
// of arbitration gets its operands latched and driven onto the multiplier, and
// it gets a one-cycle done pulse together with the product. If the multiplier
// never reports finish, the transaction is forced to complete with a zero result
// and a sticky error flag is raised.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   req_i          in   per-requester request, held until own done
//   op_a_i         in   operand M per requester, slice i = [i*N +: N]
//   op_b_i         in   operand R per requester, slice i = [i*N +: N]
//   gnt_o          out  one-hot grant, high from START through DONE
//   done_o         out  one-hot single-cycle completion pulse
//   result_o       out  product of the last transaction, held until next DONE
//   busy_o         out  high whenever the sequencer is not idle
//   timeout_err_o  out  sticky forced-completion flag, cleared only by reset
//   mul_m_o        out  multiplier operand M
//   mul_r_o        out  multiplier operand R
//   mul_enable_o   out  multiplier enable
//   mul_reset_o    out  multiplier reset
//   mul_result_i   in   multiplier product
//   mul_finish_i   in   multiplier finish flag
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*N-1:0] op_a_i,
    input  logic [NUM_REQ*N-1:0] op_b_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [N-1:0]         result_o,
    output logic                 busy_o,
    output logic                 timeout_err_o,
    output logic [N-1:0]         mul_m_o,
    output logic [N-1:0]         mul_r_o,
    output logic                 mul_enable_o,
    output logic                 mul_reset_o,
    input  logic [N-1:0]         mul_result_i,
    input  logic                 mul_finish_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [IDX_W-1:0]   ptr_q,     ptr_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [NUM_REQ-1:0] done_q,    done_d;
    logic [N-1:0]       result_q,  result_d;
    logic               busy_q,    busy_d;
    logic               err_q,     err_d;
    logic [N-1:0]       mul_m_q,   mul_m_d;
    logic [N-1:0]       mul_r_q,   mul_r_d;
    logic               mul_en_q,  mul_en_d;
    logic               mul_rst_q, mul_rst_d;

    logic               winFound;
    logic [IDX_W-1:0]   winIdx;
    logic [IDX_W-1:0]   candIdx;
    logic [N-1:0]       winOpA;
    logic [N-1:0]       winOpB;

    // Round-robin pick: first active request scanning upward from ptr, wrapping.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!winFound && req_i[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        winOpA = '0;
        winOpB = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(winIdx)) begin
                winOpA = op_a_i[k*N +: N];
                winOpB = op_b_i[k*N +: N];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        result_d  = result_q;
        busy_d    = busy_q;
        err_d     = err_q;
        mul_m_d   = mul_m_q;
        mul_r_d   = mul_r_q;
        mul_en_d  = mul_en_q;
        mul_rst_d = mul_rst_q;

        case (state_q)
            ST_IDLE: begin
                if (winFound) begin
                    idx_d     = winIdx;
                    mul_m_d   = winOpA;
                    mul_r_d   = winOpB;
                    gnt_d     = NUM_REQ'(1) << winIdx;
                    mul_en_d  = 1'b1;
                    mul_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                mul_en_d  = 1'b1;
                mul_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A finish on the last allowed cycle still counts as a good result.
                if (mul_finish_i) begin
                    result_d = mul_result_i;
                    done_d   = NUM_REQ'(1) << idx_q;
                    mul_en_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = NUM_REQ'(1) << idx_q;
                    mul_en_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            mul_m_q   <= '0;
            mul_r_q   <= '0;
            mul_en_q  <= 1'b0;
            mul_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            mul_m_q   <= mul_m_d;
            mul_r_q   <= mul_r_d;
            mul_en_q  <= mul_en_d;
            mul_rst_q <= mul_rst_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = err_q;
    assign mul_m_o       = mul_m_q;
    assign mul_r_o       = mul_r_q;
    assign mul_enable_o  = mul_en_q;
    assign mul_reset_o   = mul_rst_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Directed bench for mul_share_arbiter with a behavioural Multiplier stub whose
// product is (M*R)>>8 and whose finish rises a programmable number of cycles
// after the multiplier reset drops.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int TO = 16;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR*W-1:0] opA;
    logic [NR*W-1:0] opB;
    logic [NR-1:0] gnt_o;
    logic [NR-1:0] done_o;
    logic [W-1:0]  result_o;
    logic          busy_o;
    logic          timeout_err_o;
    logic [W-1:0]  mul_m_o;
    logic [W-1:0]  mul_r_o;
    logic          mul_enable_o;
    logic          mul_reset_o;
    logic [W-1:0]  mulResult;
    logic          mulFinish;

    int checks = 0;
    int passes = 0;

    logic [7:0]  stubCnt;
    int          stubLat;
    bit          neverFinish;
    bit          finishForce;
    logic [31:0] stubProd;

    mul_share_arbiter #(.NUM_REQ(NR), .N(W), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req),
        .op_a_i(opA),
        .op_b_i(opB),
        .gnt_o(gnt_o),
        .done_o(done_o),
        .result_o(result_o),
        .busy_o(busy_o),
        .timeout_err_o(timeout_err_o),
        .mul_m_o(mul_m_o),
        .mul_r_o(mul_r_o),
        .mul_enable_o(mul_enable_o),
        .mul_reset_o(mul_reset_o),
        .mul_result_i(mulResult),
        .mul_finish_i(mulFinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stub: counts enabled cycles since its reset dropped.
    always_ff @(posedge clk) begin
        if (mul_reset_o || !mul_enable_o) stubCnt <= 8'd0;
        else if (stubCnt != 8'hFF)        stubCnt <= stubCnt + 8'd1;
    end
    assign stubProd  = {16'd0, mul_m_o} * {16'd0, mul_r_o};
    assign mulResult = stubProd[23:8];
    assign mulFinish = finishForce |
                       (mul_enable_o && !mul_reset_o && !neverFinish && (int'(stubCnt) == stubLat));

    // Waits on negedges for a done pulse; cycles = -1 when the bound expires.
    task automatic wait_done(input int maxCycles, output int cycles);
        cycles = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge clk);
            if (done_o != '0) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; finishForce = 1'b0; neverFinish = 1'b0; stubLat = 3;
        opA = '0; opB = '0;
        @(negedge clk); @(negedge clk);
        checks++; if (gnt_o !== 4'b0) $display("[TB] FAIL reset_gnt got %b want 0000", gnt_o); else passes++;
        checks++; if (done_o !== 4'b0) $display("[TB] FAIL reset_done got %b want 0000", done_o); else passes++;
        checks++; if ({busy_o, timeout_err_o, mul_enable_o, mul_reset_o} !== 4'b0)
            $display("[TB] FAIL reset_flags got %b want 0000", {busy_o, timeout_err_o, mul_enable_o, mul_reset_o}); else passes++;
        checks++; if ({result_o, mul_m_o, mul_r_o} !== 48'd0)
            $display("[TB] FAIL reset_data got %h want 0", {result_o, mul_m_o, mul_r_o}); else passes++;
        reset = 1'b0;
        // Stray finish while idle must not start anything.
        finishForce = 1'b1; @(negedge clk); finishForce = 1'b0; @(negedge clk);
        checks++; if ({busy_o, done_o, gnt_o} !== 9'd0)
            $display("[TB] FAIL idle_finish_ignored got %b want 0", {busy_o, done_o, gnt_o}); else passes++;
    endtask

    task automatic test_single;
        int cyc;
        stubLat = 5;
        opA[1*W +: W] = 16'h0100; opB[1*W +: W] = 16'h0200;
        req = 4'b0010;
        @(negedge clk);
        checks++; if (gnt_o !== 4'b0010) $display("[TB] FAIL single_gnt got %b want 0010", gnt_o); else passes++;
        checks++; if ({mul_enable_o, mul_reset_o, busy_o} !== 3'b111)
            $display("[TB] FAIL single_start_ctl got %b want 111", {mul_enable_o, mul_reset_o, busy_o}); else passes++;
        checks++; if (mul_m_o !== 16'h0100 || mul_r_o !== 16'h0200)
            $display("[TB] FAIL single_operands got %h/%h want 0100/0200", mul_m_o, mul_r_o); else passes++;
        @(negedge clk);
        checks++; if ({mul_enable_o, mul_reset_o} !== 2'b10)
            $display("[TB] FAIL single_wait_ctl got %b want 10", {mul_enable_o, mul_reset_o}); else passes++;
        wait_done(20, cyc);
        checks++; if (cyc !== 6) $display("[TB] FAIL single_latency got %0d want 6", cyc); else passes++;
        checks++; if (done_o !== 4'b0010) $display("[TB] FAIL single_done got %b want 0010", done_o); else passes++;
        checks++; if (result_o !== 16'h0200) $display("[TB] FAIL single_result got %h want 0200", result_o); else passes++;
        checks++; if ({gnt_o, mul_enable_o, timeout_err_o} !== 6'b0010_0_0)
            $display("[TB] FAIL single_done_state got %b want 001000", {gnt_o, mul_enable_o, timeout_err_o}); else passes++;
        req = '0;
        @(negedge clk);
        checks++; if ({gnt_o, done_o, busy_o} !== 9'd0)
            $display("[TB] FAIL single_after got %b want 0", {gnt_o, done_o, busy_o}); else passes++;
        checks++; if (result_o !== 16'h0200) $display("[TB] FAIL single_result_held got %h want 0200", result_o); else passes++;
    endtask

    task automatic test_round_robin;
        logic [W-1:0] aTab [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        logic [W-1:0] bTab [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        logic [W-1:0] eTab [4] = '{16'h0010, 16'h0040, 16'h0090, 16'h0100};
        logic [NR-1:0] mask;
        int cyc;
        stubLat = 3;
        for (int i = 0; i < NR; i++) begin
            opA[i*W +: W] = aTab[i];
            opB[i*W +: W] = bTab[i];
        end
        reset = 1'b1; req = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            mask = 4'b0001 << i;
            checks++; if (gnt_o !== mask) $display("[TB] FAIL rr_gnt%0d got %b want %b", i, gnt_o, mask); else passes++;
            wait_done(20, cyc);
            checks++; if (cyc !== 5 || done_o !== mask)
                $display("[TB] FAIL rr_done%0d got %b after %0d want %b after 5", i, done_o, cyc, mask); else passes++;
            checks++; if (result_o !== eTab[i]) $display("[TB] FAIL rr_result%0d got %h want %h", i, result_o, eTab[i]); else passes++;
            req[i] = 1'b0;
            @(negedge clk);
            checks++; if ({busy_o, gnt_o} !== 5'd0) $display("[TB] FAIL rr_idle%0d got %b want 0", i, {busy_o, gnt_o}); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_alternate;
        int seq [4] = '{0, 2, 0, 2};
        logic [NR-1:0] mask;
        int cyc;
        stubLat = 1;
        // Sequencer is in IDLE with ptr back at 0.
        req = 4'b0101;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mask = 4'b0001 << seq[i];
            checks++; if (gnt_o !== mask) $display("[TB] FAIL alt_gnt%0d got %b want %b", i, gnt_o, mask); else passes++;
            wait_done(20, cyc);
            checks++; if (done_o !== mask) $display("[TB] FAIL alt_done%0d got %b want %b", i, done_o, mask); else passes++;
            @(negedge clk);
            if (i == 3) req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        neverFinish = 1'b1;
        opA[3*W +: W] = 16'h0100; opB[3*W +: W] = 16'h0123;
        req = 4'b1000;
        @(negedge clk);
        checks++; if (gnt_o !== 4'b1000) $display("[TB] FAIL to_gnt got %b want 1000", gnt_o); else passes++;
        wait_done(TO + 8, cyc);
        checks++; if (cyc !== TO + 1) $display("[TB] FAIL to_latency got %0d want %0d", cyc, TO + 1); else passes++;
        checks++; if ({done_o, result_o, timeout_err_o} !== {4'b1000, 16'h0000, 1'b1})
            $display("[TB] FAIL to_done got %b/%h/%b want 1000/0000/1", done_o, result_o, timeout_err_o); else passes++;
        req = '0;
        @(negedge clk);
        neverFinish = 1'b0; stubLat = 2;
        opA[0*W +: W] = 16'h0400; opB[0*W +: W] = 16'h0050;
        req = 4'b0001;
        @(negedge clk);
        wait_done(20, cyc);
        checks++; if (done_o !== 4'b0001 || result_o !== 16'h0140)
            $display("[TB] FAIL to_good got %b/%h want 0001/0140", done_o, result_o); else passes++;
        checks++; if (timeout_err_o !== 1'b1) $display("[TB] FAIL to_sticky got %b want 1", timeout_err_o); else passes++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int cyc;
        neverFinish = 1'b1;
        opA[1*W +: W] = 16'h0100; opB[1*W +: W] = 16'h0300;
        req = 4'b0010;
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b1; req = 4'b1000;
        @(negedge clk);
        checks++; if ({gnt_o, done_o, busy_o, timeout_err_o, mul_enable_o, mul_reset_o} !== 12'd0)
            $display("[TB] FAIL rst_wait_ctl got %b want 0",
                     {gnt_o, done_o, busy_o, timeout_err_o, mul_enable_o, mul_reset_o}); else passes++;
        checks++; if ({result_o, mul_m_o, mul_r_o} !== 48'd0)
            $display("[TB] FAIL rst_wait_data got %h want 0", {result_o, mul_m_o, mul_r_o}); else passes++;
        reset = 1'b0; neverFinish = 1'b0; stubLat = 2;
        @(negedge clk);
        checks++; if (gnt_o !== 4'b1000 || mul_m_o !== 16'h0100)
            $display("[TB] FAIL rst_regrant got %b/%h want 1000/0100", gnt_o, mul_m_o); else passes++;
        wait_done(20, cyc);
        checks++; if (done_o !== 4'b1000 || result_o !== 16'h0123)
            $display("[TB] FAIL rst_result got %b/%h want 1000/0123", done_o, result_o); else passes++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_operand_latch;
        int cyc;
        stubLat = 4;
        opA[2*W +: W] = 16'h0300; opB[2*W +: W] = 16'h0040;
        req = 4'b0100;
        @(negedge clk); @(negedge clk); @(negedge clk);
        req = '0; opA[2*W +: W] = 16'h7777; opB[2*W +: W] = 16'h1111;
        wait_done(20, cyc);
        checks++; if (cyc !== 4) $display("[TB] FAIL latch_latency got %0d want 4", cyc); else passes++;
        checks++; if (done_o !== 4'b0100 || result_o !== 16'h00C0)
            $display("[TB] FAIL latch_result got %b/%h want 0100/00c0", done_o, result_o); else passes++;
        checks++; if (mul_m_o !== 16'h0300) $display("[TB] FAIL latch_mul_m got %h want 0300", mul_m_o); else passes++;
        @(negedge clk);
    endtask

    task automatic test_finish_wins;
        int cyc;
        stubLat = TO - 1;
        opA[0*W +: W] = 16'h0200; opB[0*W +: W] = 16'h0300;
        req = 4'b0001;
        @(negedge clk);
        wait_done(TO + 8, cyc);
        checks++; if (cyc !== TO + 1) $display("[TB] FAIL fw_latency got %0d want %0d", cyc, TO + 1); else passes++;
        checks++; if ({done_o, result_o, timeout_err_o} !== {4'b0001, 16'h0600, 1'b0})
            $display("[TB] FAIL fw_done got %b/%h/%b want 0001/0600/0", done_o, result_o, timeout_err_o); else passes++;
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_alternate();
        test_timeout();
        test_reset_mid_wait();
        test_operand_latch();
        test_finish_wins();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
